// File: rtl/gba_bus_arbiter_if.sv
//==============================================================================
// Module   : gba_bus_arbiter_if
// Purpose  : CPU, DMA and downstream memory buses of the GBA bus arbiter
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface gba_bus_arbiter_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_width;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_ok;
    logic [31:0] cpu_rdata;

    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [1:0]  dma_width;
    logic        dma_read;
    logic        dma_write;
    logic        dma_lock;
    logic        dma_ok;
    logic [31:0] dma_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ok;
    logic [31:0] mem_rdata;

    logic        owner;

    // Arbiter view: requests in, completions out, downstream strobes out
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_width, cpu_read, cpu_write,
        output cpu_ok, cpu_rdata,
        input  dma_addr, dma_wdata, dma_width, dma_read, dma_write, dma_lock,
        output dma_ok, dma_rdata,
        output mem_addr, mem_wdata, mem_width, mem_read, mem_write,
        input  mem_ok, mem_rdata,
        output owner
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_width, cpu_read, cpu_write,
        input  cpu_ok, cpu_rdata,
        output dma_addr, dma_wdata, dma_width, dma_read, dma_write, dma_lock,
        input  dma_ok, dma_rdata,
        input  mem_addr, mem_wdata, mem_width, mem_read, mem_write,
        output mem_ok, mem_rdata,
        input  owner
    );
endinterface

`default_nettype wire

// File: rtl/gba_bus_arbiter.sv
//==============================================================================
// Module   : gba_bus_arbiter
// Purpose  : CPU/DMA arbiter for the system memory port with region wait states
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module gba_bus_arbiter #(
    parameter int WS_EWRAM = 2,
    parameter int WS_ROM   = 3,
    parameter int WS_OTHER = 0,
    parameter int WS_BITS  = 3
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    gba_bus_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    localparam logic [WS_BITS-1:0] c_ws_ewram = WS_BITS'(WS_EWRAM);
    localparam logic [WS_BITS-1:0] c_ws_rom   = WS_BITS'(WS_ROM);
    localparam logic [WS_BITS-1:0] c_ws_other = WS_BITS'(WS_OTHER);
    localparam logic [WS_BITS-1:0] c_ws_one   = WS_BITS'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_owner;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_width;
    logic               r_write;
    logic [WS_BITS-1:0] r_wcnt;

    logic               w_cpu_pend;
    logic               w_dma_pend;
    logic               w_any_pend;
    logic               w_sel;
    logic [31:0]        w_sel_addr;
    logic [WS_BITS-1:0] w_sel_ws;
    logic               w_xfer;
    logic               w_done;

    function automatic logic [WS_BITS-1:0] ws_of(input logic [3:0] region);
        if (region == 4'h2)
            return c_ws_ewram;
        else if (region >= 4'h8 && region <= 4'hD)
            return c_ws_rom;
        else
            return c_ws_other;
    endfunction

    assign w_cpu_pend = bus.cpu_read | bus.cpu_write;
    assign w_dma_pend = bus.dma_read | bus.dma_write;
    assign w_any_pend = w_cpu_pend | w_dma_pend;

    // A locked DMA burst keeps the bus; otherwise contention alternates owners
    always_comb begin
        w_sel = w_dma_pend;
        if (r_owner && bus.dma_lock && w_dma_pend)
            w_sel = 1'b1;
        else if (w_cpu_pend && w_dma_pend)
            w_sel = ~r_owner;
    end

    assign w_sel_addr = w_sel ? bus.dma_addr : bus.cpu_addr;
    assign w_sel_ws   = ws_of(w_sel_addr[27:24]);

    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any_pend) w_next = (w_sel_ws != '0) ? S_WAIT : S_XFER;
            S_WAIT: if (r_wcnt <= c_ws_one) w_next = S_XFER;
            S_XFER: if (bus.mem_ok) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request is captured once in IDLE; later changes on the requester side are ignored
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_width <= '0;
            r_write <= 1'b0;
            r_wcnt  <= '0;
        end else if (r_state == S_IDLE && w_any_pend) begin
            r_owner <= w_sel;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel ? bus.dma_wdata : bus.cpu_wdata;
            r_width <= w_sel ? bus.dma_width : bus.cpu_width;
            r_write <= w_sel ? (bus.dma_write & ~bus.dma_read)
                             : (bus.cpu_write & ~bus.cpu_read);
            r_wcnt  <= w_sel_ws;
        end else if (r_state == S_WAIT && r_wcnt > c_ws_one) begin
            r_wcnt  <= r_wcnt - c_ws_one;
        end
    end

    // rstn gates completion so an access cut off by reset never reports ok
    always_comb begin
        w_xfer         = (r_state == S_XFER);
        w_done         = w_xfer & bus.mem_ok & rstn;
        bus.mem_read   = w_xfer & ~r_write;
        bus.mem_write  = w_xfer & r_write;
        bus.mem_addr   = w_xfer ? r_addr  : 32'h0;
        bus.mem_wdata  = w_xfer ? r_wdata : 32'h0;
        bus.mem_width  = w_xfer ? r_width : 2'd2;
        bus.cpu_ok     = w_done & ~r_owner;
        bus.dma_ok     = w_done & r_owner;
        bus.cpu_rdata  = (w_done & ~r_owner) ? bus.mem_rdata : 32'h0;
        bus.dma_rdata  = (w_done & r_owner)  ? bus.mem_rdata : 32'h0;
        bus.owner      = r_owner;
    end

endmodule

`default_nettype wire

// File: doc/gba_bus_arbiter.md
Name: gba_bus_arbiter

Overview:
- Shares the single system memory port between the ARMv4T core and the DMA engine.
- Grants one requester at a time and latches its request.
- Inserts region-dependent wait states, then drives the downstream memory and routes the completion back to the owner.
- Sits between the core's memory interface (after the top-level tri-state split into separate addr/wdata/rdata buses) and the memory/IO decoder.

Parameters:
- WS_EWRAM, 2, extra wait cycles before issuing an access to region addr[27:24]==4'h2
- WS_ROM, 3, extra wait cycles for region addr[27:24] in 4'h8..4'hD
- WS_OTHER, 0, extra wait cycles for all other regions
- WS_BITS, 3, width of the wait counter; every WS_* value must be <= 2**WS_BITS-1

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- cpu_addr  input  32  CPU byte address
- cpu_wdata  input  32  CPU write data
- cpu_width  input  2  log2 bytes (0 byte, 1 half, 2 word)
- cpu_read  input  1  CPU read request, held until cpu_ok
- cpu_write  input  1  CPU write request, held until cpu_ok
- cpu_ok  output  1  one-cycle completion pulse to CPU
- cpu_rdata  output  32  read data, valid when cpu_ok=1
- dma_addr, dma_wdata, dma_width, dma_read, dma_write  input  32/32/2/1/1  DMA request, same rules as CPU
- dma_lock  input  1  DMA holds the bus across consecutive transfers (burst)
- dma_ok  output  1  one-cycle completion pulse to DMA
- dma_rdata  output  32  read data, valid when dma_ok=1
- mem_addr  output  32  downstream address
- mem_wdata  output  32  downstream write data
- mem_width  output  2  downstream width
- mem_read  output  1  downstream read strobe
- mem_write  output  1  downstream write strobe
- mem_ok  input  1  downstream completion, one cycle
- mem_rdata  input  32  downstream read data, valid with mem_ok
- owner  output  1  current/last grant (0 CPU, 1 DMA), for debug/DMA status

Behaviour:
- Requester pending = read|write. read and write asserted together: treat as read.
- FSM states:
  - S_IDLE: no downstream strobe. If any requester is pending, select it (see priority). Latch addr, wdata, width, direction into regs; set owner. Load the wait counter with WS for latched addr[27:24]. Next state is S_WAIT if WS>0, else S_XFER.
  - S_WAIT: counter decrements each cycle; go to S_XFER in the cycle the counter reaches 1. Downstream strobes stay low.
  - S_XFER: mem_addr/wdata/width come from latched regs; mem_read or mem_write=1 per latched direction; hold until mem_ok. On mem_ok: owner's ok=1 combinationally in the same cycle, rdata=mem_rdata combinationally, next state S_IDLE.
- Priority, evaluated in S_IDLE only:
  - If owner==DMA and dma_lock and dma pending: DMA.
  - Else if both pending: grant the one that is not owner (round-robin).
  - Else the single pending one.
- No preemption once latched.
- Latency: minimum 1 (IDLE) + WS + memory cycles from request to ok. Consecutive transfers from one requester therefore always have one idle bus cycle between them.
- Requester requests are sampled only in S_IDLE. Changes to addr/data after latch are ignored.
- A requester dropping its request during S_WAIT/S_XFER is illegal. The downstream access still completes, and its ok pulse is still issued, then ignored by the requester.
- Non-owner ok is always 0. Non-owner rdata is 32'h0.
- mem_ok outside S_XFER is ignored.
- Wait counter never wraps: it loads only in S_IDLE and stops at 1.
- Reset (rstn=0 at a clk edge, any state):
  - state=S_IDLE, owner=0, latched regs=0.
  - Outputs after that edge: mem_read=mem_write=0, mem_addr=mem_wdata=0, mem_width=2, cpu_ok=dma_ok=0, rdata=0.
  - An in-flight access is abandoned without any ok.
- All outputs except ok/rdata are registered or decoded from the state alone. No combinational path from cpu_*/dma_* inputs to mem_*.

Test Plan:
- CPU read 0x08000000, WS_ROM=3, memory ok 1 cycle after strobe with rdata=0xE3A00013 -> mem_read rises in cycle 5 after request (IDLE + 3 wait cycles); cpu_ok=1 for one cycle with cpu_rdata=0xE3A00013; dma_ok stays 0.
- CPU and DMA both request in the same cycle, owner=0 -> DMA granted first. Then CPU is served next, with the round-robin rule applied even though DMA re-requested.
- DMA with dma_lock=1 issues 4 word writes to 0x02000000..0x0200000C while the CPU requests continuously -> all 4 DMA writes complete before the CPU is granted; each write has WS_EWRAM=2 wait cycles and mem_width=2.
- CPU byte write to 0x04000000 (WS_OTHER=0), with cpu_addr/wdata changed to 0xFFFFFFFF after the latch -> mem_addr=0x04000000, mem_width=0, original wdata presented. Grant-to-strobe is 1 cycle with no wait.
- Reset asserted during S_WAIT of a DMA read -> next cycle is IDLE with no strobes and no dma_ok. After release, a pending CPU request is granted normally.
- mem_ok pulsed while in S_IDLE/S_WAIT -> no ok to either requester, and no state change apart from the normal countdown.
